// File: rtl/puzzle_move_unit.sv
// Slide-move executor for the 2x3 sliding puzzle: reads board/count, validates the move, writes back board, count and history.
// Optional MOVE_REVERSE_BLOCK_EN: adds a PRELOAD cycle and rejects a move that undoes the previous one.
module puzzle_move_unit #(
    parameter int          DATA_W    = 40,
    parameter logic [3:0]  BOARD_REG = 4'd0,
    parameter logic [3:0]  CNT_REG   = 4'd1,
    parameter logic [3:0]  ORD_REG   = 4'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_dir,
    output logic [3:0]        src0,
    output logic [3:0]        src1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              we,
    output logic [3:0]        dst,
    output logic [DATA_W-1:0] data,
    output logic              done,
    output logic              illegal,
    output logic              solved
);
    localparam logic [1:0]  DIR_UP    = 2'b00;
    localparam logic [1:0]  DIR_DOWN  = 2'b01;
    localparam logic [1:0]  DIR_LEFT  = 2'b10;
    localparam logic [1:0]  DIR_RIGHT = 2'b11;
    localparam logic [17:0] GOAL      = 18'b001_010_011_100_101_000;

    typedef enum logic [2:0] {
        S_IDLE, S_PRELOAD, S_LOAD, S_WB_BOARD, S_WB_CNT, S_WB_ORD, S_FIN, S_REJECT
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          dir_q, dir_d;
    logic [17:0]         board_q, board_d;
    logic [DATA_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   ord_q, ord_d;
    logic                solved_q, solved_d;

    logic [2:0]          blank_cnt;
    logic [2:0]          blank_pos;
    logic [2:0]          col;
    logic [2:0]          tgt;
    logic                move_ok;
    logic [17:0]         new_board;
    logic                unused_hi;

    assign unused_hi = ^data0[DATA_W-1:18];
    assign solved    = solved_q;

    // Blank search and move evaluation work directly on the live read data during LOAD.
    always_comb begin
        blank_cnt = '0;
        blank_pos = '0;
        for (int i = 0; i < 6; i++) begin
            if (data0[17-3*i -: 3] == 3'd0) begin
                blank_cnt = blank_cnt + 3'd1;
                blank_pos = 3'(i);
            end
        end
        col     = (blank_pos >= 3'd3) ? blank_pos - 3'd3 : blank_pos;
        move_ok = 1'b0;
        tgt     = blank_pos;
        case (dir_q)
            DIR_UP:    begin move_ok = (blank_pos >= 3'd3); tgt = blank_pos - 3'd3; end
            DIR_DOWN:  begin move_ok = (blank_pos <  3'd3); tgt = blank_pos + 3'd3; end
            DIR_LEFT:  begin move_ok = (col != 3'd0);       tgt = blank_pos - 3'd1; end
            default:   begin move_ok = (col != 3'd2);       tgt = blank_pos + 3'd1; end
        endcase
        if (blank_cnt != 3'd1) move_ok = 1'b0;
`ifdef MOVE_REVERSE_BLOCK_EN
        if ((data1 != '0) && ((dir_q ^ 2'b01) == ord_q[1:0])) move_ok = 1'b0;
`endif
        new_board = data0[17:0];
        if (move_ok) begin
            new_board[17-3*int'(blank_pos) -: 3] = data0[17-3*int'(tgt) -: 3];
            new_board[17-3*int'(tgt) -: 3]       = 3'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        board_d   = board_q;
        cnt_d     = cnt_q;
        ord_d     = ord_q;
        solved_d  = solved_q;
        cmd_ready = 1'b0;
        src0      = '0;
        src1      = '0;
        we        = 1'b0;
        dst       = '0;
        data      = '0;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    dir_d = cmd_dir;
`ifdef MOVE_REVERSE_BLOCK_EN
                    state_d = S_PRELOAD;
`else
                    state_d = S_LOAD;
`endif
                end
            end
            S_PRELOAD: begin
                src0    = ORD_REG;
                ord_d   = data0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                src0    = BOARD_REG;
                src1    = CNT_REG;
                cnt_d   = data1;
                board_d = new_board;
                state_d = move_ok ? S_WB_BOARD : S_REJECT;
            end
            S_WB_BOARD: begin
                we      = 1'b1;
                dst     = BOARD_REG;
                data    = DATA_W'(board_q);
                state_d = S_WB_CNT;
            end
            S_WB_CNT: begin
                we      = 1'b1;
                dst     = CNT_REG;
                data    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                src1    = ORD_REG;
                ord_d   = data1;
                state_d = S_WB_ORD;
            end
            S_WB_ORD: begin
                we      = 1'b1;
                dst     = ORD_REG;
                data    = {ord_q[DATA_W-3:0], dir_q};
                state_d = S_FIN;
            end
            S_FIN: begin
                done     = 1'b1;
                solved_d = (board_q == GOAL);
                state_d  = S_IDLE;
            end
            S_REJECT: begin
                done    = 1'b1;
                illegal = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dir_q    <= '0;
            board_q  <= '0;
            cnt_q    <= '0;
            ord_q    <= '0;
            solved_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            board_q  <= board_d;
            cnt_q    <= cnt_d;
            ord_q    <= ord_d;
            solved_q <= solved_d;
        end
    end
endmodule

// File: tb/tb_puzzle_move_unit.sv
// Directed bench for puzzle_move_unit with a behavioural 16-entry register file.
module tb_puzzle_move_unit;
    localparam int DW = 40;
`ifdef MOVE_REVERSE_BLOCK_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam logic [39:0] B0      = 40'({18'b001_010_100_101_011_000});
    localparam logic [39:0] B_UP    = 40'({18'b001_010_000_101_011_100});
    localparam logic [39:0] B_UPL   = 40'({18'b001_000_010_101_011_100});
    localparam logic [39:0] B_PRE   = 40'({18'b001_010_011_100_000_101});
    localparam logic [39:0] B_GOAL  = 40'({18'b001_010_011_100_101_000});

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_dir = 2'b00;
    logic [3:0]    src0, src1, dst;
    logic [DW-1:0] data0, data1, data;
    logic          we, done, illegal, solved;

    logic [DW-1:0] rf [16];
    logic          pl_en = 1'b0;
    logic [3:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int errors = 0;
    int checks = 0;

    puzzle_move_unit #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .src0(src0), .src1(src1), .data0(data0), .data1(data1),
        .we(we), .dst(dst), .data(data), .done(done), .illegal(illegal), .solved(solved)
    );

    always #5 clk = ~clk;

    assign data0 = rf[src0];
    assign data1 = rf[src1];

    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (we) rf[dst] <= data;
    end

    task automatic preload(input logic [3:0] a, input logic [DW-1:0] v);
        pl_addr = a;
        pl_data = v;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
        @(negedge clk);
    endtask

    // Issues one command from a negedge; lat = cycle index (1 = first after accept) where done is seen, -1 on timeout.
    task automatic run_cmd(input logic [1:0] d, output int lat, output logic ill, output int wes);
        lat = -1; ill = 1'b0; wes = 0;
        cmd_valid = 1'b1;
        cmd_dir   = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_dir = ~d;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (we) wes++;
            if (done) begin
                lat = c;
                ill = illegal;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic load_initial();
        preload(4'd0, B0);
        preload(4'd1, 40'd0);
        preload(4'd2, 40'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, we, dst, src0, src1, done, illegal, solved} !== {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%b dst=%0d src0=%0d src1=%0d done=%b ill=%b solved=%b, required ready=1 rest 0",
                     cmd_ready, we, dst, src0, src1, done, illegal, solved);
        end
        checks++;
        if (data !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_legal_up();
        int lat; logic ill; int wes;
        load_initial();
        checks++;
        if (src0 !== 4'd0 || src1 !== 4'd0) begin errors++; $display("FAIL idle_src: src0=%0d src1=%0d required 0", src0, src1); end
        run_cmd(2'b00, lat, ill, wes);
        checks++; if (lat !== 5 + EXTRA) begin errors++; $display("FAIL up_latency: got %0d required %0d", lat, 5 + EXTRA); end
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL up_illegal: got %b required 0", ill); end
        checks++; if (wes !== 3) begin errors++; $display("FAIL up_we_count: got %0d required 3", wes); end
        checks++; if (rf[0] !== B_UP) begin errors++; $display("FAIL up_board: got %h required %h", rf[0], B_UP); end
        checks++; if (rf[1] !== 40'd1) begin errors++; $display("FAIL up_cnt: got %h required 1", rf[1]); end
        checks++; if (rf[2] !== 40'd0) begin errors++; $display("FAIL up_ord: got %h required 0", rf[2]); end
    endtask

    task automatic test_illegal();
        int lat; logic ill; int wes;
        logic [1:0] dirs [2];
        dirs[0] = 2'b01;
        dirs[1] = 2'b11;
        load_initial();
        for (int k = 0; k < 2; k++) begin
            run_cmd(dirs[k], lat, ill, wes);
            checks++; if (lat !== 2 + EXTRA) begin errors++; $display("FAIL rej_latency[%0d]: got %0d required %0d", k, lat, 2 + EXTRA); end
            checks++; if (ill !== 1'b1) begin errors++; $display("FAIL rej_illegal[%0d]: got %b required 1", k, ill); end
            checks++; if (wes !== 0) begin errors++; $display("FAIL rej_we[%0d]: got %0d required 0", k, wes); end
        end
        checks++;
        if (rf[0] !== B0 || rf[1] !== 40'd0 || rf[2] !== 40'd0) begin
            errors++; $display("FAIL rej_regs: board=%h cnt=%h ord=%h required %h 0 0", rf[0], rf[1], rf[2], B0);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic ill; int wes;
        load_initial();
        run_cmd(2'b00, lat, ill, wes);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", cmd_ready); end
        run_cmd(2'b10, lat, ill, wes);
        checks++; if (ill !== 1'b0 || lat !== 5 + EXTRA) begin errors++; $display("FAIL b2b_left: ill=%b lat=%0d required 0 %0d", ill, lat, 5 + EXTRA); end
        checks++; if (rf[0] !== B_UPL) begin errors++; $display("FAIL b2b_board: got %h required %h", rf[0], B_UPL); end
        checks++; if (rf[1] !== 40'd2) begin errors++; $display("FAIL b2b_cnt: got %h required 2", rf[1]); end
        checks++; if (rf[2] !== 40'h2) begin errors++; $display("FAIL b2b_ord: got %h required 2", rf[2]); end
    endtask

    task automatic test_solved();
        int lat; logic ill; int wes;
        preload(4'd0, B_PRE);
        preload(4'd1, 40'd0);
        preload(4'd2, 40'd0);
        run_cmd(2'b11, lat, ill, wes);
        checks++; if (rf[0] !== B_GOAL) begin errors++; $display("FAIL solve_board: got %h required %h", rf[0], B_GOAL); end
        checks++; if (solved !== 1'b1) begin errors++; $display("FAIL solve_flag: got %b required 1", solved); end
        run_cmd(2'b10, lat, ill, wes);
`ifdef MOVE_REVERSE_BLOCK_EN
        checks++; if (ill !== 1'b1) begin errors++; $display("FAIL unsolve_illegal: got %b required 1", ill); end
        checks++; if (solved !== 1'b1) begin errors++; $display("FAIL unsolve_flag: got %b required 1", solved); end
`else
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL unsolve_illegal: got %b required 0", ill); end
        checks++; if (rf[0] !== B_PRE) begin errors++; $display("FAIL unsolve_board: got %h required %h", rf[0], B_PRE); end
        checks++; if (solved !== 1'b0) begin errors++; $display("FAIL unsolve_flag: got %b required 0", solved); end
`endif
    endtask

    task automatic test_saturate();
        int lat; logic ill; int wes;
        preload(4'd0, B0);
        preload(4'd1, 40'hFF_FFFF_FFFF);
        preload(4'd2, 40'hFF_FFFF_FFFF);
        run_cmd(2'b00, lat, ill, wes);
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL sat_illegal: got %b required 0", ill); end
        checks++; if (rf[1] !== 40'hFF_FFFF_FFFF) begin errors++; $display("FAIL sat_cnt: got %h required ffffffffff", rf[1]); end
        checks++; if (rf[2] !== 40'hFF_FFFF_FFFC) begin errors++; $display("FAIL sat_ord: got %h required fffffffffc", rf[2]); end
    endtask

    task automatic test_reset_mid();
        preload(4'd0, B0);
        preload(4'd1, 40'd5);
        preload(4'd2, 40'd0);
        cmd_valid = 1'b1;
        cmd_dir   = 2'b00;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3 + EXTRA) @(negedge clk);
        checks++; if (we !== 1'b1 || dst !== 4'd1) begin errors++; $display("FAIL mid_in_wbcnt: we=%b dst=%0d required 1 1", we, dst); end
        rst = 1'b1;
        #1;
        checks++;
        if ({we, dst, src0, src1, done, illegal, cmd_ready} !== {1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1} || data !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: we=%b dst=%0d src0=%0d src1=%0d data=%h ready=%b required reset values", we, dst, src0, src1, data, cmd_ready);
        end
        @(negedge clk);
        checks++; if (rf[0] !== B_UP) begin errors++; $display("FAIL mid_board: got %h required %h", rf[0], B_UP); end
        checks++; if (rf[1] !== 40'd5) begin errors++; $display("FAIL mid_cnt: got %h required 5", rf[1]); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || we !== 1'b0) begin errors++; $display("FAIL mid_after_release: ready=%b we=%b required 1 0", cmd_ready, we); end
    endtask

    initial begin
        test_reset();
        test_legal_up();
        test_illegal();
        test_back_to_back();
        test_solved();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
